// File: rtl/output_controller_pkg.sv
// Shared router definitions for the output-port arbiter/switch.
// Flit framing bits, FSM encoding and default port geometry.
package output_controller_pkg;

    localparam int DEFAULT_DATA_WIDTH = 70;
    localparam int DEFAULT_CHANNELS   = 5;

    localparam int BOP_BIT  = DEFAULT_DATA_WIDTH - 1;
    localparam int EOP_BIT  = DEFAULT_DATA_WIDTH - 2;
    localparam int LOCAL_CH = DEFAULT_CHANNELS - 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/output_controller_if.sv
// Request/data bundle between the input controllers, one output controller
// and the downstream output buffer. The slave modport is the output controller.
interface output_controller_if #(
    parameter int DATA_WIDTH      = 70,
    parameter int NUMBER_CHANNELS = 5
);
    logic [NUMBER_CHANNELS-1:0]            req;
    logic [NUMBER_CHANNELS-1:0]            rok;
    logic [NUMBER_CHANNELS*DATA_WIDTH-1:0] din;
    logic [NUMBER_CHANNELS-1:0]            rd;
    logic                                  wok;
    logic                                  wr;
    logic [DATA_WIDTH-1:0]                 dout;
    logic [NUMBER_CHANNELS-1:0]            gnt;
    logic                                  idle;

    modport master (
        output req, rok, din, wok,
        input  rd, wr, dout, gnt, idle
    );

    modport slave (
        input  req, rok, din, wok,
        output rd, wr, dout, gnt, idle
    );
endinterface

// File: rtl/output_controller_rr_arbiter.sv
// Combinational rotating-priority pick: scans rr_ptr+1, rr_ptr+2, ... modulo N
// and returns the first requester as one-hot plus its index.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  win,
    output logic [PW-1:0] win_idx,
    output logic          valid
);

    int            idx;
    logic [PW-1:0] sel;

    always_comb begin
        win     = '0;
        win_idx = '0;
        valid   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 1; k <= N; k++) begin
            // rr_ptr never exceeds N-1, so one wrap subtraction is enough
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            sel = PW'(idx);
            if (!valid && req[sel]) begin
                valid    = 1'b1;
                win[sel] = 1'b1;
                win_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/output_controller.sv
// Per-output-port arbiter/switch: grants one input round-robin, holds the grant
// for a whole packet and forwards its flits to the downstream buffer.
module output_controller
    import output_controller_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int NUMBER_CHANNELS = DEFAULT_CHANNELS
) (
    input  logic                 clk,
    input  logic                 rst,
    output_controller_if.slave   bus,
    output state_t               dbg_state
);

    localparam int N       = NUMBER_CHANNELS;
    localparam int PW      = (N > 1) ? $clog2(N) : 1;
    localparam int EOP_POS = DATA_WIDTH - 2;

    state_t                state;
    logic [N-1:0]          gnt_q;
    logic [PW-1:0]         g_idx;
    logic [PW-1:0]         rr_ptr;
    logic                  idle_q;

    logic [N-1:0]          win;
    logic [PW-1:0]         win_idx;
    logic                  win_valid;
    logic [DATA_WIDTH-1:0] sel_flit;
    logic                  transfer;

    rr_arbiter #(.N(N), .PW(PW)) u_arb (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .win     (win),
        .win_idx (win_idx),
        .valid   (win_valid)
    );

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) sel_flit = bus.din[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A flit moves when the granted input has one (rok) and downstream can take
    // it (wok); rd to the source and wr to the sink both fire in that same cycle.
    assign transfer  = (state == ST_BUSY) && (|(bus.rok & gnt_q)) && bus.wok;
    assign bus.wr    = transfer;
    assign bus.rd    = transfer ? gnt_q : '0;
    assign bus.dout  = (state == ST_BUSY) ? sel_flit : '0;
    assign bus.gnt   = gnt_q;
    assign bus.idle  = idle_q;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            gnt_q  <= '0;
            g_idx  <= '0;
            rr_ptr <= PW'(N - 1);
            idle_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        state  <= ST_BUSY;
                        gnt_q  <= win;
                        g_idx  <= win_idx;
                        idle_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // the winner drops to lowest priority for the next pick
                    if (transfer && sel_flit[EOP_POS]) begin
                        state  <= ST_IDLE;
                        gnt_q  <= '0;
                        rr_ptr <= g_idx;
                        idle_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    gnt_q  <= '0;
                    idle_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_controller.sv
// Bench for output_controller: per-input packet queues feed the DUT, a
// packet-level round-robin model predicts grants and a scoreboard checks flits.
module tb_output_controller;
    import output_controller_pkg::*;

    localparam int DW = DEFAULT_DATA_WIDTH;
    localparam int N  = DEFAULT_CHANNELS;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_t dbg_state;

    output_controller_if #(.DATA_WIDTH(DW), .NUMBER_CHANNELS(N)) bus();

    output_controller #(.DATA_WIDTH(DW), .NUMBER_CHANNELS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] fq [N][$];
    logic [DW-1:0] exp_q[$];

    bit  m_busy;
    int  m_g;
    int  m_ptr;

    int  wok_mode;
    bit  rok_rand;
    int  gnt_req_mode;

    logic [N-1:0]  req_drv;
    logic [N-1:0]  rok_drv;
    logic          wok_drv;
    logic [DW-1:0] din_drv [N];

    int   grant_log[$];
    int   gap_log[$];
    int   idle_run;
    logic [N-1:0] prev_gnt;
    int   wr_cnt;
    int   rd_cnt [N];

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Winner = requester with the smallest forward distance past the last winner.
    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            int d;
            d = (i - ptr - 1 + 2 * N) % N;
            if (r[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    function automatic bit any_pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (fq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic make_packet(input int ch, input int len);
        for (int k = 0; k < len; k++) begin
            logic [DW-1:0] f;
            f = '0;
            f[31:0]     = $urandom;
            f[63:32]    = $urandom;
            f[67:64]    = 4'($urandom_range(0, 15));
            f[BOP_BIT]  = (k == 0);
            f[EOP_BIT]  = (k == len - 1);
            fq[ch].push_back(f);
        end
    endtask

    task automatic drive_inputs();
        logic [N*DW-1:0] dp;
        dp = '0;
        for (int i = 0; i < N; i++) begin
            bit has;
            has        = fq[i].size() > 0;
            din_drv[i] = has ? fq[i][0] : '0;
            rok_drv[i] = has && (!rok_rand || $urandom_range(0, 3) != 0);
            if (m_busy && i == m_g) begin
                case (gnt_req_mode)
                    1:       req_drv[i] = 1'($urandom_range(0, 1));
                    2:       req_drv[i] = 1'b0;
                    default: req_drv[i] = has;
                endcase
            end else begin
                req_drv[i] = has;
            end
            dp[i*DW +: DW] = din_drv[i];
        end
        wok_drv = (wok_mode == 2) ? ($urandom_range(0, 3) != 0) : (wok_mode == 1);
        bus.req = req_drv;
        bus.rok = rok_drv;
        bus.wok = wok_drv;
        bus.din = dp;
    endtask

    task automatic check_outputs();
        logic [N-1:0]  one_n;
        logic [N-1:0]  exp_gnt;
        logic [N-1:0]  exp_rd;
        logic [DW-1:0] exp_dout;
        bit            exp_xfer;
        one_n    = 1;
        exp_gnt  = m_busy ? (one_n << m_g) : '0;
        exp_xfer = m_busy && rok_drv[m_g] && wok_drv;
        exp_rd   = exp_xfer ? exp_gnt : '0;
        exp_dout = m_busy ? din_drv[m_g] : '0;
        check_eq("gnt",   DW'(bus.gnt),   DW'(exp_gnt));
        check_eq("idle",  DW'(bus.idle),  DW'(!m_busy));
        check_eq("state", DW'(dbg_state), DW'(m_busy));
        check_eq("wr",    DW'(bus.wr),    DW'(exp_xfer));
        check_eq("rd",    DW'(bus.rd),    DW'(exp_rd));
        check_eq("dout",  bus.dout,       exp_dout);
        if (exp_xfer) begin
            check_eq("sb_avail", DW'(exp_q.size() > 0), DW'(1));
            if (exp_q.size() > 0) check_eq("sb_dout", bus.dout, exp_q[0]);
        end
        if (bus.gnt == '0) begin
            idle_run++;
        end else if (prev_gnt == '0) begin
            grant_log.push_back(oh_idx(bus.gnt));
            gap_log.push_back(idle_run);
            idle_run = 0;
        end
        prev_gnt = bus.gnt;
        wr_cnt  += int'(bus.wr);
        for (int i = 0; i < N; i++) rd_cnt[i] += int'(bus.rd[i]);
    endtask

    task automatic update_model();
        if (!m_busy) begin
            if (req_drv != '0) begin
                m_g    = rr_pick(req_drv, m_ptr);
                m_busy = 1'b1;
                for (int k = 0; k < fq[m_g].size(); k++) begin
                    exp_q.push_back(fq[m_g][k]);
                    if (fq[m_g][k][EOP_BIT]) break;
                end
            end
        end else if (rok_drv[m_g] && wok_drv) begin
            logic [DW-1:0] f;
            f = fq[m_g].pop_front();
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (f[EOP_BIT]) begin
                m_busy = 1'b0;
                m_ptr  = m_g;
            end
        end
    endtask

    task automatic step();
        drive_inputs();
        #1;
        check_outputs();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst     = 1'b0;
        bus.req = '0;
        bus.rok = '0;
        bus.wok = 1'b0;
        bus.din = '0;
        for (int i = 0; i < N; i++) fq[i].delete();
        exp_q.delete();
        m_busy = 1'b0;
        m_g    = 0;
        m_ptr  = N - 1;
        #1;
        check_eq("rst_gnt",  DW'(bus.gnt),  DW'(0));
        check_eq("rst_idle", DW'(bus.idle), DW'(1));
        check_eq("rst_wr",   DW'(bus.wr),   DW'(0));
        check_eq("rst_rd",   DW'(bus.rd),   DW'(0));
        check_eq("rst_dout", bus.dout,      DW'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        grant_log.delete();
        gap_log.delete();
        idle_run = 0;
        prev_gnt = '0;
        wr_cnt   = 0;
        for (int i = 0; i < N; i++) rd_cnt[i] = 0;
        wok_mode     = 1;
        rok_rand     = 1'b0;
        gnt_req_mode = 0;
    endtask

    task automatic run_until_done(input int max_cycles);
        int c = 0;
        while ((m_busy || any_pending()) && c < max_cycles) begin
            step();
            c++;
        end
        step();
        check_eq("drain_done", DW'(m_busy || any_pending()), DW'(0));
    endtask

    function automatic int order_code();
        int code = 0;
        for (int k = 0; k < grant_log.size(); k++) code = code * 8 + grant_log[k] + 1;
        return code;
    endfunction

    function automatic int bad_gaps();
        int b = 0;
        for (int k = 1; k < gap_log.size(); k++) if (gap_log[k] != 1) b++;
        return b;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // single 3-flit packet on input 2
        apply_reset();
        make_packet(2, 3);
        run_until_done(30);
        check_eq("s1_order", DW'(order_code()), DW'('o3));
        check_eq("s1_wr",    DW'(wr_cnt),       DW'(3));
        check_eq("s1_rd2",   DW'(rd_cnt[2]),    DW'(3));
        check_eq("s1_idle",  DW'(bus.idle),     DW'(1));

        // all inputs requesting, 1-flit packets
        apply_reset();
        for (int i = 0; i < N; i++) make_packet(i, 1);
        make_packet(0, 1);
        run_until_done(40);
        check_eq("s2_order", DW'(order_code()), DW'('o123451));
        check_eq("s2_gaps",  DW'(bad_gaps()),   DW'(0));
        check_eq("s2_wr",    DW'(wr_cnt),       DW'(6));

        // downstream stall mid-packet on input 1
        apply_reset();
        make_packet(1, 4);
        step();
        step();
        wok_mode = 0;
        repeat (4) step();
        wok_mode = 1;
        run_until_done(30);
        check_eq("s3_order", DW'(order_code()), DW'('o2));
        check_eq("s3_wr",    DW'(wr_cnt),       DW'(4));
        check_eq("s3_rd1",   DW'(rd_cnt[1]),    DW'(4));

        // req drops on the granted input, a competitor waits for eop
        apply_reset();
        make_packet(3, 3);
        step();
        step();
        gnt_req_mode = 2;
        make_packet(0, 2);
        run_until_done(30);
        check_eq("s4_order", DW'(order_code()), DW'('o41));
        check_eq("s4_wr",    DW'(wr_cnt),       DW'(5));

        // asynchronous reset mid-packet
        apply_reset();
        make_packet(2, 5);
        repeat (3) step();
        check_eq("s5_busy", DW'(bus.gnt), DW'(5'b00100));
        #3;
        rst = 1'b0;
        #1;
        check_eq("s5_async_gnt", DW'(bus.gnt), DW'(0));
        check_eq("s5_async_wr",  DW'(bus.wr),  DW'(0));
        check_eq("s5_async_rd",  DW'(bus.rd),  DW'(0));
        apply_reset();
        make_packet(3, 1);
        make_packet(0, 1);
        make_packet(4, 1);
        run_until_done(30);
        check_eq("s5_order", DW'(order_code()), DW'('o145));

        // single bop=eop flit on the local port
        apply_reset();
        make_packet(LOCAL_CH, 1);
        run_until_done(20);
        check_eq("s6_order", DW'(order_code()),      DW'('o5));
        check_eq("s6_wr",    DW'(wr_cnt),            DW'(1));
        check_eq("s6_rd4",   DW'(rd_cnt[LOCAL_CH]),  DW'(1));
        check_eq("s6_rd0",   DW'(rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3]), DW'(0));

        // randomized traffic with stalls and jittering req
        apply_reset();
        wok_mode     = 2;
        rok_rand     = 1'b1;
        gnt_req_mode = 1;
        repeat (500) begin
            if ($urandom_range(0, 3) == 0) make_packet($urandom_range(0, N - 1), $urandom_range(1, 4));
            step();
        end
        wok_mode     = 1;
        rok_rand     = 1'b0;
        run_until_done(3000);
        check_eq("rand_sb_empty", DW'(exp_q.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
